// File: rtl/axis_frame_join_ctrl.sv
// Join-group sequencer in front of an AXI4-Stream frame joiner: holds sources until every
// port has a frame pending, releases them as one tagged group, and drops groups that time out.
module axis_frame_join_ctrl #(
  parameter int unsigned S_COUNT    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TAG_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned STAT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT-1:0]            s_axis_tuser,
  output logic [S_COUNT*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [S_COUNT-1:0]            m_axis_tvalid,
  input  logic [S_COUNT-1:0]            m_axis_tready,
  output logic [S_COUNT-1:0]            m_axis_tlast,
  output logic [S_COUNT-1:0]            m_axis_tuser,
  input  logic                          enable,
  input  logic [CNT_WIDTH-1:0]          timeout,
  output logic [TAG_WIDTH-1:0]          tag,
  output logic                          busy,
  output logic [STAT_WIDTH-1:0]         join_count,
  output logic [STAT_WIDTH-1:0]         drop_count
);

  typedef enum logic [1:0] {StIdle, StWait, StRun, StDrop} state_e;

  state_e                  state_q, state_d;
  logic [TAG_WIDTH-1:0]    tag_q, tag_d;
  logic [STAT_WIDTH-1:0]   join_count_q, join_count_d;
  logic [STAT_WIDTH-1:0]   drop_count_q, drop_count_d;
  logic [CNT_WIDTH-1:0]    timer_q, timer_d;
  logic [S_COUNT-1:0]      done_mask_q, done_mask_d;
  logic [S_COUNT-1:0]      drop_mask_q, drop_mask_d;
  logic [S_COUNT-1:0]      last_hs;
  logic                    all_valid;
  logic                    any_valid;
  logic                    timeout_hit;

  assign m_axis_tdata = s_axis_tdata;
  assign m_axis_tlast = s_axis_tlast;
  assign m_axis_tuser = s_axis_tuser;

  assign tag        = tag_q;
  assign join_count = join_count_q;
  assign drop_count = drop_count_q;
  assign busy       = (state_q != StIdle);

  assign all_valid   = &s_axis_tvalid;
  assign any_valid   = |s_axis_tvalid;
  assign timeout_hit = (timeout != '0) && (timer_q == timeout - CNT_WIDTH'(1));
  assign last_hs     = s_axis_tvalid & s_axis_tready & s_axis_tlast;

  // Valid/ready gating is decoded from registered state only, so reset gates it instantly.
  always_comb begin
    m_axis_tvalid = '0;
    s_axis_tready = '0;
    case (state_q)
      StRun: begin
        m_axis_tvalid = s_axis_tvalid & ~done_mask_q;
        s_axis_tready = m_axis_tready & ~done_mask_q;
      end
      StDrop: s_axis_tready = drop_mask_q;
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    join_count_d = join_count_q;
    drop_count_d = drop_count_q;
    timer_d      = timer_q;
    done_mask_d  = done_mask_q;
    drop_mask_d  = drop_mask_q;
    case (state_q)
      StIdle: begin
        if (enable && all_valid) begin
          state_d = StRun;
        end else if (enable && any_valid) begin
          state_d = StWait;
          timer_d = '0;
        end
      end
      StWait: begin
        if (timer_q != '1) timer_d = timer_q + CNT_WIDTH'(1);
        // A group completing on the timeout cycle still wins.
        if (all_valid) begin
          state_d = StRun;
        end else if (timeout_hit) begin
          state_d     = StDrop;
          drop_mask_d = s_axis_tvalid;
        end
      end
      StRun: begin
        done_mask_d = done_mask_q | last_hs;
        if (last_hs[S_COUNT-1]) begin
          state_d      = StIdle;
          tag_d        = tag_q + TAG_WIDTH'(1);
          join_count_d = join_count_q + STAT_WIDTH'(1);
          done_mask_d  = '0;
        end
      end
      StDrop: begin
        if (drop_mask_q == '0) begin
          state_d      = StIdle;
          drop_count_d = drop_count_q + STAT_WIDTH'(1);
        end else begin
          drop_mask_d = drop_mask_q & ~last_hs;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      tag_q        <= '0;
      join_count_q <= '0;
      drop_count_q <= '0;
      timer_q      <= '0;
      done_mask_q  <= '0;
      drop_mask_q  <= '0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      join_count_q <= join_count_d;
      drop_count_q <= drop_count_d;
      timer_q      <= timer_d;
      done_mask_q  <= done_mask_d;
      drop_mask_q  <= drop_mask_d;
    end
  end

endmodule

// File: tb/tb_axis_frame_join_ctrl.sv
// Directed bench for axis_frame_join_ctrl: frame sources, a port-ordered joiner model with
// optional random backpressure, and a per-port scoreboard of expected beats and tags.
module tb_axis_frame_join_ctrl;
  localparam int S  = 4;
  localparam int DW = 8;
  localparam int TW = 16;
  localparam int CW = 16;
  localparam int SW = 32;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
    logic          u;
    logic [TW-1:0] t;
  } beat_t;

  logic            clk;
  logic            rst;
  logic [S*DW-1:0] s_tdata, m_tdata;
  logic [S-1:0]    s_tvalid, s_tready, s_tlast, s_tuser;
  logic [S-1:0]    m_tvalid, m_tready, m_tlast, m_tuser;
  logic            enable;
  logic [CW-1:0]   timeout;
  logic [TW-1:0]   tag;
  logic            busy;
  logic [SW-1:0]   join_count, drop_count;

  axis_frame_join_ctrl #(
    .S_COUNT(S), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .CNT_WIDTH(CW), .STAT_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .enable(enable), .timeout(timeout), .tag(tag), .busy(busy),
    .join_count(join_count), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t        src_q[S][$];
  beat_t        exp_q[S][$];
  logic [S-1:0] port_en;
  logic [S-1:0] done_f;
  int           jport;
  bit           rand_rdy;
  logic         rdy_now;
  logic [DW-1:0] seed_d;
  int           n_cmp, n_err, gate_viol, beats_seen;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < S; i++) begin
      s_tvalid[i] = port_en[i] && (src_q[i].size() > 0);
      if (src_q[i].size() > 0) begin
        s_tdata[i*DW +: DW] = src_q[i][0].d;
        s_tlast[i]          = src_q[i][0].l;
        s_tuser[i]          = src_q[i][0].u;
      end else begin
        s_tdata[i*DW +: DW] = '0;
        s_tlast[i]          = 1'b0;
        s_tuser[i]          = 1'b0;
      end
    end
    m_tready = '0;
    if (rdy_now) m_tready[jport] = 1'b1;
  endtask

  task automatic add_frame(input int p, input int len, input bit joined, input logic [TW-1:0] tg);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d = seed_d;
      seed_d++;
      b.l = (k == len - 1);
      b.u = 1'($urandom_range(0, 1));
      b.t = tg;
      src_q[p].push_back(b);
      if (joined) exp_q[p].push_back(b);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < S; i++) n += exp_q[i].size();
    return n;
  endfunction

  // Sample on the falling edge, advance sources and joiner after the rising edge.
  task automatic tick();
    logic [S-1:0] s_hs;
    beat_t eb;
    @(negedge clk);
    s_hs = s_tvalid & s_tready;
    if (!rst) begin
      if (!busy) done_f = '0;
      if (m_tdata !== s_tdata || m_tlast !== s_tlast || m_tuser !== s_tuser) gate_viol++;
      if (!busy && (m_tvalid != '0 || s_tready != '0)) gate_viol++;
      for (int i = 0; i < S; i++) begin
        if (m_tvalid[i] && (done_f[i] || exp_q[i].size() == 0)) gate_viol++;
        if (m_tvalid[i] && m_tready[i]) begin
          if (!s_hs[i]) gate_viol++;
          if (exp_q[i].size() == 0) begin
            check_eq($sformatf("spurious_beat_p%0d", i), 64'd1, 64'd0);
          end else begin
            eb = exp_q[i].pop_front();
            check_eq($sformatf("beat_p%0d", i),
                     64'({m_tdata[i*DW +: DW], m_tlast[i], m_tuser[i], tag}), 64'(eb));
            beats_seen++;
          end
          if (m_tlast[i]) begin
            done_f[i] = 1'b1;
            jport = (jport == S - 1) ? 0 : jport + 1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < S; i++) if (s_hs[i]) void'(src_q[i].pop_front());
    if (rand_rdy) rdy_now = 1'($urandom_range(0, 1));
    drive();
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int k = 0;
    tick();
    while ((busy || pending() > 0) && k < budget) begin
      tick();
      k++;
    end
    check_eq({"in_budget_", name}, 64'(k < budget), 64'd1);
  endtask

  task automatic clear_all();
    for (int i = 0; i < S; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    done_f  = '0;
    jport   = 0;
    port_en = '1;
  endtask

  int cnt;
  int b0;
  int total;

  initial begin
    n_cmp = 0; n_err = 0; gate_viol = 0; beats_seen = 0; seed_d = 8'h10;
    rst = 1'b1; enable = 1'b1; timeout = '0; rand_rdy = 1'b0; rdy_now = 1'b1;
    clear_all();
    // Test 1 frames are already presented while reset is held.
    add_frame(0, 3, 1, 16'd0); add_frame(1, 2, 1, 16'd0);
    add_frame(2, 4, 1, 16'd0); add_frame(3, 1, 1, 16'd0);
    drive();
    #22;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_tag", 64'(tag), 64'd0);
    check_eq("rst_join", 64'(join_count), 64'd0);
    check_eq("rst_drop", 64'(drop_count), 64'd0);
    check_eq("rst_mvalid", 64'(m_tvalid), 64'd0);
    check_eq("rst_sready", 64'(s_tready), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Test 1: all ports valid, 3/2/4/1 beats, joiner walks ports in order.
    @(posedge clk);
    #1;
    check_eq("t1_run_after_1", 64'(busy), 64'd1);
    check_eq("t1_mvalid_all", 64'(m_tvalid), 64'hf);
    run_until_idle("t1", 200);
    check_eq("t1_beats", 64'(beats_seen), 64'd10);
    check_eq("t1_tag", 64'(tag), 64'd1);
    check_eq("t1_join", 64'(join_count), 64'd1);

    // Test 7: enable low holds IDLE; raising it starts the group on the next edge.
    enable = 1'b0;
    for (int p = 0; p < S; p++) add_frame(p, 2, 1, 16'd1);
    drive();
    repeat (5) tick();
    check_eq("t7_idle", 64'(busy), 64'd0);
    check_eq("t7_no_beats", 64'(beats_seen), 64'd10);
    enable = 1'b1;
    tick();
    check_eq("t7_started", 64'(busy), 64'd1);
    run_until_idle("t7", 200);
    check_eq("t7_join", 64'(join_count), 64'd2);
    check_eq("t7_tag", 64'(tag), 64'd2);

    // Test 4: port 0 queues a second frame right after its first; it must wait for IDLE.
    add_frame(0, 1, 1, 16'd2); add_frame(0, 2, 1, 16'd3);
    for (int p = 1; p < S; p++) begin
      add_frame(p, 3, 1, 16'd2);
      add_frame(p, 1, 1, 16'd3);
    end
    drive();
    run_until_idle("t4", 400);
    check_eq("t4_join", 64'(join_count), 64'd4);
    check_eq("t4_tag", 64'(tag), 64'd4);
    check_eq("t4_gating", 64'(gate_viol), 64'd0);

    // Test 2: port 3 never arrives; 16 WAIT cycles, then ports 0-2 drained in DROP.
    timeout = 16'd16;
    port_en = 4'b0111;
    for (int p = 0; p < 3; p++) add_frame(p, 2, 0, 16'd0);
    drive();
    tick();
    cnt = 0;
    while (busy && s_tready == '0 && cnt < 100) begin
      cnt++;
      tick();
    end
    check_eq("t2_wait_cycles", 64'(cnt), 64'd16);
    run_until_idle("t2", 100);
    check_eq("t2_drop", 64'(drop_count), 64'd1);
    check_eq("t2_tag", 64'(tag), 64'd4);
    check_eq("t2_join", 64'(join_count), 64'd4);
    check_eq("t2_consumed", 64'(src_q[0].size() + src_q[1].size() + src_q[2].size()), 64'd0);
    check_eq("t2_gating", 64'(gate_viol), 64'd0);

    // Test 3: port 3 turns valid exactly while timer == timeout-1.
    for (int p = 0; p < S; p++) add_frame(p, 2, 1, 16'd4);
    drive();
    tick();
    repeat (15) tick();
    port_en = '1;
    drive();
    tick();
    check_eq("t3_run", 64'(busy), 64'd1);
    check_eq("t3_mvalid", 64'(m_tvalid), 64'hf);
    run_until_idle("t3", 100);
    check_eq("t3_drop", 64'(drop_count), 64'd1);
    check_eq("t3_join", 64'(join_count), 64'd5);
    check_eq("t3_tag", 64'(tag), 64'd5);

    // Test 6: asynchronous reset in the middle of RUN.
    timeout = '0;
    for (int p = 0; p < S; p++) add_frame(p, 4, 1, 16'd5);
    drive();
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_mvalid", 64'(m_tvalid), 64'd0);
    check_eq("t6_sready", 64'(s_tready), 64'd0);
    check_eq("t6_busy", 64'(busy), 64'd0);
    check_eq("t6_tag", 64'(tag), 64'd0);
    check_eq("t6_join", 64'(join_count), 64'd0);
    check_eq("t6_drop", 64'(drop_count), 64'd0);
    clear_all();
    drive();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Test 5: 100 groups under random joiner backpressure.
    rand_rdy = 1'b1;
    b0 = beats_seen;
    total = 0;
    for (int g = 0; g < 100; g++) begin
      for (int p = 0; p < S; p++) begin
        cnt = int'($urandom_range(1, 4));
        total += cnt;
        add_frame(p, cnt, 1, TW'(g));
      end
    end
    drive();
    run_until_idle("t5", 30000);
    check_eq("t5_beats", 64'(beats_seen - b0), 64'(total));
    check_eq("t5_join", 64'(join_count), 64'd100);
    check_eq("t5_tag", 64'(tag), 64'd100);
    check_eq("t5_drop", 64'(drop_count), 64'd0);
    check_eq("final_gating", 64'(gate_viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
